// File: rtl/core_intc_pkg.sv
// core_intc_pkg: shared types and constants for the core_intc interrupt controller.
`default_nettype none

package core_intc_pkg;

    typedef enum logic [1:0] {
        SVC_RESET = 2'd0,
        IDLE      = 2'd1,
        SVC_NMI   = 2'd2,
        SVC_IRQ   = 2'd3
    } intc_state_t;

    localparam int IDX_W = 4;
    localparam int SRC_W = 5;

    localparam logic [SRC_W-1:0] SRC_NONE  = 5'd0;
    localparam logic [SRC_W-1:0] SRC_NMI   = 5'd30;
    localparam logic [SRC_W-1:0] SRC_RESET = 5'd31;

    localparam logic [1:0] CFG_SEL_ENABLE = 2'd0;
    localparam logic [1:0] CFG_SEL_EDGE   = 2'd1;
    localparam logic [1:0] CFG_SEL_W1C    = 2'd2;
    localparam logic [1:0] CFG_SEL_RSVD   = 2'd3;

endpackage

`default_nettype wire

// File: rtl/core_intc_prio.sv
// core_intc_prio: combinational lowest-index-wins priority encoder.
`default_nettype none

module core_intc_prio
    import core_intc_pkg::*;
#(
    parameter int N_IRQ = 8
) (
    input  logic [N_IRQ-1:0] req,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    always_comb begin
        valid = |req;
        index = '0;
        // Scan downward so the lowest set bit is the last assignment.
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = IDX_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/core_intc.sv
// core_intc: reset/NMI/N_IRQ arbiter for the 6502-style core, serviced at instruction boundaries.
// Build option: define CORE_INTC_VECTORED_EN to give each IRQ channel its own vector below VEC_IRQ_BASE.
`default_nettype none

module core_intc
    import core_intc_pkg::*;
#(
    parameter int          N_IRQ        = 8,
    parameter logic [15:0] VEC_RESET    = 16'hFFFC,
    parameter logic [15:0] VEC_NMI      = 16'hFFFA,
    parameter logic [15:0] VEC_IRQ      = 16'hFFFE,
    parameter logic [15:0] VEC_IRQ_BASE = 16'hFFDE
) (
    input  logic             I_clock,
    input  logic             I_reset,
    input  logic             I_enable,
    input  logic             I_ack,
    input  logic             I_nmi,
    input  logic [N_IRQ-1:0] I_irq,
    input  logic             I_irq_mask,
    input  logic             I_cfg_wr,
    input  logic [1:0]       I_cfg_sel,
    input  logic [N_IRQ-1:0] I_cfg_data,
    output logic [N_IRQ-1:0] O_pending,
    output logic [4:0]       O_source,
    output logic             O_force_brk,
    output logic             O_irq_mask,
    output logic [15:0]      O_vec_addr_lo,
    output logic [15:0]      O_vec_addr_hi
);

    intc_state_t state;
    intc_state_t next_state;

    logic             nmi_q;
    logic             nmi_pending;
    logic [N_IRQ-1:0] irq_q;
    logic [N_IRQ-1:0] irq_enable;
    logic [N_IRQ-1:0] edge_mode;
    logic [N_IRQ-1:0] edge_pend;

    logic [IDX_W-1:0] svc_idx;
    logic [15:0]      svc_vec;

    logic             take_nmi;
    logic             take_irq;
    logic             win_valid;
    logic [IDX_W-1:0] win_idx;
    logic             irq_req;
    logic [15:0]      irq_vec;

    logic             nmi_fall;
    logic             nmi_clear;
    logic [N_IRQ-1:0] irq_fall;
    logic [N_IRQ-1:0] w1c_mask;
    logic [N_IRQ-1:0] ack_mask;
    logic [15:0]      vec_lo;

    // Level channels follow the pin directly; edge channels show the latched bit.
    always_comb begin
        for (int i = 0; i < N_IRQ; i++) begin
            O_pending[i] = edge_mode[i] ? edge_pend[i] : ~I_irq[i];
        end
    end

    core_intc_prio #(
        .N_IRQ (N_IRQ)
    ) u_prio (
        .req   (O_pending & irq_enable),
        .valid (win_valid),
        .index (win_idx)
    );

    assign irq_req = win_valid & ~I_irq_mask;

`ifdef CORE_INTC_VECTORED_EN
    assign irq_vec = VEC_IRQ_BASE - {11'd0, win_idx, 1'b0};
`else
    logic unused_base;
    assign unused_base = ^VEC_IRQ_BASE;
    assign irq_vec     = VEC_IRQ;
`endif

    always_comb begin
        next_state = state;
        take_nmi   = 1'b0;
        take_irq   = 1'b0;
        case (state)
            IDLE: begin
                if (I_enable) begin
                    if (nmi_pending) begin
                        next_state = SVC_NMI;
                        take_nmi   = 1'b1;
                    end else if (irq_req) begin
                        next_state = SVC_IRQ;
                        take_irq   = 1'b1;
                    end
                end
            end
            SVC_RESET, SVC_NMI, SVC_IRQ: begin
                if (I_ack) begin
                    next_state = IDLE;
                end
            end
            default: next_state = SVC_RESET;
        endcase
    end

    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            state <= SVC_RESET;
        end else begin
            state <= next_state;
        end
    end

    assign nmi_fall  = nmi_q & ~I_nmi;
    assign nmi_clear = (state == SVC_NMI) & I_ack;
    assign irq_fall  = irq_q & ~I_irq & edge_mode;
    assign w1c_mask  = (I_cfg_wr && I_cfg_sel == CFG_SEL_W1C) ? I_cfg_data : '0;

    always_comb begin
        for (int i = 0; i < N_IRQ; i++) begin
            ack_mask[i] = (state == SVC_IRQ) && I_ack && (svc_idx == IDX_W'(i));
        end
    end

    // A new edge always beats a same-clock clear, for NMI and channels alike.
    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            nmi_q       <= 1'b1;
            nmi_pending <= 1'b0;
            irq_q       <= '1;
            edge_pend   <= '0;
        end else begin
            nmi_q       <= I_nmi;
            nmi_pending <= nmi_fall | (nmi_pending & ~nmi_clear);
            irq_q       <= I_irq;
            edge_pend   <= irq_fall | (edge_pend & ~(w1c_mask | ack_mask));
        end
    end

    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            irq_enable <= '0;
            edge_mode  <= '0;
        end else if (I_cfg_wr) begin
            case (I_cfg_sel)
                CFG_SEL_ENABLE: irq_enable <= I_cfg_data;
                CFG_SEL_EDGE:   edge_mode  <= I_cfg_data;
                default:        ;
            endcase
        end
    end

    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            svc_idx <= '0;
            svc_vec <= VEC_IRQ;
        end else if (take_irq) begin
            svc_idx <= win_idx;
            svc_vec <= irq_vec;
        end
    end

    always_comb begin
        O_source    = SRC_NONE;
        O_force_brk = 1'b0;
        O_irq_mask  = 1'b0;
        vec_lo      = VEC_IRQ;
        case (state)
            SVC_RESET: begin
                O_source    = SRC_RESET;
                O_force_brk = 1'b1;
                O_irq_mask  = 1'b1;
                vec_lo      = VEC_RESET;
            end
            SVC_NMI: begin
                O_source    = SRC_NMI;
                O_force_brk = 1'b1;
                O_irq_mask  = 1'b1;
                vec_lo      = VEC_NMI;
            end
            SVC_IRQ: begin
                O_source    = {1'b0, svc_idx} + 5'd1;
                O_force_brk = 1'b1;
                O_irq_mask  = 1'b1;
                vec_lo      = svc_vec;
            end
            default: ;
        endcase
    end

    assign O_vec_addr_lo = vec_lo;
    assign O_vec_addr_hi = vec_lo + 16'd1;

endmodule

`default_nettype wire
